// File: rtl/nv_nvdla_bdma_intr_gen_if.sv
// Pop handshake between the BDMA store interrupt FIFO and the interrupt generator.
// The FIFO is the master and offers entries; the generator is the slave and pops them.
interface nv_nvdla_bdma_intr_gen_if;
   logic fifo_intr_rd_pvld;
   logic fifo_intr_rd_pd;
   logic fifo_intr_rd_prdy;

   modport master (output fifo_intr_rd_pvld, output fifo_intr_rd_pd, input fifo_intr_rd_prdy);
   modport slave  (input fifo_intr_rd_pvld, input fifo_intr_rd_pd, output fifo_intr_rd_prdy);
endinterface

// File: rtl/nv_nvdla_bdma_intr_gen.sv
// BDMA done-interrupt generator: pops interrupt FIFO entries, emits single-cycle
// pulses toward GLB with a minimum gap, and keeps per-group saturating counters.
//
// state | meaning
// IDLE  | ready to pop; an offered entry is accepted this cycle
// PULSE | one cycle, drives the (unmasked) pulse and bumps the group counter
// GAP   | INTR_GAP forced idle cycles before the next pop
module nv_nvdla_bdma_intr_gen #(
   parameter int INTR_GAP = 2,
   parameter int CNT_W    = 8
) (
   input  logic                     nvdla_core_clk,
   input  logic                     nvdla_core_rst,
   nv_nvdla_bdma_intr_gen_if.slave  intr_fifo,
   input  logic [1:0]               reg2dp_intr_mask,
   input  logic [1:0]               reg2dp_cnt_clr,
   output logic [1:0]               bdma2glb_done_intr_pd,
   output logic                     dp2reg_intr_ptr,
   output logic [CNT_W-1:0]         dp2reg_done_cnt0,
   output logic [CNT_W-1:0]         dp2reg_done_cnt1,
   output logic                     intr_idle
);

   localparam int GW = (INTR_GAP > 1) ? $clog2(INTR_GAP) : 1;
   localparam logic [GW-1:0] GAP_LOAD = (INTR_GAP > 0) ? GW'(INTR_GAP - 1) : '0;

   typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

   state_t           state, state_nxt;
   logic             grp, grp_nxt;
   logic [GW-1:0]    gap_cnt, gap_cnt_nxt;
   logic [CNT_W-1:0] done_cnt [2];
   logic             pulse_vld;
   logic [1:0]       grp_inc;

   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst) begin
         state   <= IDLE;
         grp     <= 1'b0;
         gap_cnt <= '0;
      end else begin
         state   <= state_nxt;
         grp     <= grp_nxt;
         gap_cnt <= gap_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      grp_nxt     = grp;
      gap_cnt_nxt = gap_cnt;
      case (state)
         IDLE: begin
            if (intr_fifo.fifo_intr_rd_pvld) begin
               grp_nxt   = intr_fifo.fifo_intr_rd_pd;
               state_nxt = PULSE;
            end
         end
         PULSE: begin
            if (INTR_GAP == 0) begin
               state_nxt = IDLE;
            end else begin
               gap_cnt_nxt = GAP_LOAD;
               state_nxt   = GAP;
            end
         end
         GAP: begin
            if (gap_cnt == '0) state_nxt = IDLE;
            else               gap_cnt_nxt = gap_cnt - 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign pulse_vld = (state == PULSE);
   assign grp_inc   = pulse_vld ? (grp ? 2'b10 : 2'b01) : 2'b00;

   // clear wins over the old value, but an increment in the same cycle still counts
   always_ff @(posedge nvdla_core_clk) begin
      if (nvdla_core_rst) begin
         done_cnt[0]     <= '0;
         done_cnt[1]     <= '0;
         dp2reg_intr_ptr <= 1'b0;
      end else begin
         for (int g = 0; g < 2; g++) begin
            if (reg2dp_cnt_clr[g])
               done_cnt[g] <= grp_inc[g] ? CNT_W'(1) : '0;
            else if (grp_inc[g] && (done_cnt[g] != '1))
               done_cnt[g] <= done_cnt[g] + 1'b1;
         end
         if (pulse_vld) dp2reg_intr_ptr <= grp;
      end
   end

   // pulse is decoded from registered state/group only; gated so reset never emits one
   assign bdma2glb_done_intr_pd       = nvdla_core_rst ? 2'b00 : (grp_inc & ~reg2dp_intr_mask);
   assign intr_fifo.fifo_intr_rd_prdy = (state == IDLE);
   assign intr_idle                   = (state == IDLE) & ~intr_fifo.fifo_intr_rd_pvld;
   assign dp2reg_done_cnt0            = done_cnt[0];
   assign dp2reg_done_cnt1            = done_cnt[1];

endmodule
